// File: rtl/ika87ad_opfetch_if.sv
// Opcode-fetch bundle: fetch bytes in, assembled
// instruction out to the decoder.
interface ika87ad_opfetch_if;
  logic       i_MCUCLK_PCEN;
  logic       i_FETCH_VLD;
  logic [7:0] i_FETCH_DATA;
  logic       i_FLUSH;
  logic       i_DEC_ACK;
  logic       o_FETCH_RDY;
  logic [7:0] o_OPCODE;
  logic [2:0] o_OPCODE_PAGE;
  logic       o_OP_VLD;
  logic       o_PREFIX_PEND;
  logic [1:0] o_FETCH_CNT;

  modport slave (
    input  i_MCUCLK_PCEN,
    input  i_FETCH_VLD,
    input  i_FETCH_DATA,
    input  i_FLUSH,
    input  i_DEC_ACK,
    output o_FETCH_RDY,
    output o_OPCODE,
    output o_OPCODE_PAGE,
    output o_OP_VLD,
    output o_PREFIX_PEND,
    output o_FETCH_CNT
  );

  modport master (
    output i_MCUCLK_PCEN,
    output i_FETCH_VLD,
    output i_FETCH_DATA,
    output i_FLUSH,
    output i_DEC_ACK,
    input  o_FETCH_RDY,
    input  o_OPCODE,
    input  o_OPCODE_PAGE,
    input  o_OP_VLD,
    input  o_PREFIX_PEND,
    input  o_FETCH_CNT
  );
endinterface

// File: rtl/ika87ad_opfetch.sv
// Opcode fetch assembler: folds an optional page
// prefix and the opcode byte into one instruction.
module ika87ad_opfetch (
  input  logic                 i_EMUCLK,
  input  logic                 i_RESET_n,
  ika87ad_opfetch_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [2:0] page_q, page_d;
  logic [1:0] cnt_q, cnt_d;

  logic       rdy;
  logic       accept;
  logic       is_pfx;
  logic [2:0] pfx_page;

  always_comb begin
    is_pfx   = 1'b1;
    pfx_page = 3'd0;
    unique case (bus.i_FETCH_DATA)
      8'h48:   pfx_page = 3'd1;
      8'h60:   pfx_page = 3'd2;
      8'h64:   pfx_page = 3'd3;
      8'h70:   pfx_page = 3'd4;
      8'h74:   pfx_page = 3'd5;
      default: is_pfx   = 1'b0;
    endcase
  end

  // HOLD passes a new byte through only when the
  // decoder is releasing the held instruction.
  assign rdy    = (state_q != HOLD) | bus.i_DEC_ACK;
  assign accept = bus.i_MCUCLK_PCEN & bus.i_FETCH_VLD & rdy;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    if (bus.i_MCUCLK_PCEN) begin
      if (bus.i_FLUSH) begin
        state_d = IDLE;
        page_d  = 3'd0;
        cnt_d   = 2'd0;
      end else begin
        unique case (state_q)
          IDLE, HOLD: begin
            if (accept) begin
              cnt_d = 2'd1;
              if (is_pfx) begin
                state_d = PREFIX;
                page_d  = pfx_page;
              end else begin
                state_d  = HOLD;
                opcode_d = bus.i_FETCH_DATA;
                page_d   = 3'd0;
              end
            end else if (state_q == HOLD && bus.i_DEC_ACK) begin
              state_d = IDLE;
              cnt_d   = 2'd0;
            end
          end
          PREFIX: begin
            if (accept) begin
              state_d  = HOLD;
              opcode_d = bus.i_FETCH_DATA;
              cnt_d    = 2'd2;
            end
          end
          default: begin
            state_d = IDLE;
            page_d  = 3'd0;
            cnt_d   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q  <= IDLE;
      opcode_q <= 8'h00;
      page_q   <= 3'd0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_FETCH_RDY   = rdy;
  assign bus.o_OPCODE      = opcode_q;
  assign bus.o_OPCODE_PAGE = page_q;
  assign bus.o_OP_VLD      = (state_q == HOLD);
  assign bus.o_PREFIX_PEND = (state_q == PREFIX);
  assign bus.o_FETCH_CNT   = cnt_q;

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Directed bench for the opcode fetch assembler.
// Each task drives one scenario and checks inline.
module tb_ika87ad_opfetch;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ika87ad_opfetch_if bus ();

  ika87ad_opfetch dut (
    .i_EMUCLK  (clk),
    .i_RESET_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic pcen, input logic vld,
                       input logic [7:0] data, input logic ack,
                       input logic flush);
    @(negedge clk);
    bus.i_MCUCLK_PCEN = pcen;
    bus.i_FETCH_VLD   = vld;
    bus.i_FETCH_DATA  = data;
    bus.i_DEC_ACK     = ack;
    bus.i_FLUSH       = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'h70, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.o_OP_VLD !== 1'b0) begin
      errors++; $display("FAIL rst_vld got %b exp 0", bus.o_OP_VLD);
    end
    checks++;
    if (bus.o_OPCODE !== 8'h00) begin
      errors++; $display("FAIL rst_op got %h exp 00", bus.o_OPCODE);
    end
    checks++;
    if (bus.o_OPCODE_PAGE !== 3'd0) begin
      errors++; $display("FAIL rst_page got %0d exp 0", bus.o_OPCODE_PAGE);
    end
    checks++;
    if (bus.o_PREFIX_PEND !== 1'b0) begin
      errors++; $display("FAIL rst_pend got %b exp 0", bus.o_PREFIX_PEND);
    end
    checks++;
    if (bus.o_FETCH_CNT !== 2'd0) begin
      errors++; $display("FAIL rst_cnt got %0d exp 0", bus.o_FETCH_CNT);
    end
    checks++;
    if (bus.o_FETCH_RDY !== 1'b1) begin
      errors++; $display("FAIL rst_rdy got %b exp 1", bus.o_FETCH_RDY);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 8'h54, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE, bus.o_FETCH_CNT}
        !== {1'b1, 8'h54, 3'd0, 2'd1}) begin
      errors++;
      $display("FAIL single got vld=%b op=%h pg=%0d cnt=%0d exp 1 54 0 1",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE, bus.o_FETCH_CNT);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_FETCH_CNT, bus.o_OPCODE}
        !== {1'b0, 2'd0, 8'h54}) begin
      errors++;
      $display("FAIL ack_idle got vld=%b cnt=%0d op=%h exp 0 0 54",
               bus.o_OP_VLD, bus.o_FETCH_CNT, bus.o_OPCODE);
    end
  endtask

  task automatic test_prefix();
    drive(1'b1, 1'b1, 8'h70, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_PREFIX_PEND, bus.o_FETCH_CNT, bus.o_OP_VLD, bus.o_OPCODE_PAGE}
        !== {1'b1, 2'd1, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL pfx got pend=%b cnt=%0d vld=%b pg=%0d exp 1 1 0 4",
               bus.o_PREFIX_PEND, bus.o_FETCH_CNT, bus.o_OP_VLD,
               bus.o_OPCODE_PAGE);
    end
    drive(1'b0, 1'b1, 8'h6A, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_PREFIX_PEND, bus.o_OP_VLD} !== 2'b10) begin
      errors++;
      $display("FAIL pcen_low got pend=%b vld=%b exp 1 0",
               bus.o_PREFIX_PEND, bus.o_OP_VLD);
    end
    drive(1'b1, 1'b1, 8'h6A, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE, bus.o_FETCH_CNT,
         bus.o_PREFIX_PEND} !== {1'b1, 8'h6A, 3'd4, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL pfx2 got vld=%b op=%h pg=%0d cnt=%0d pend=%b exp 1 6a 4 2 0",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE,
               bus.o_FETCH_CNT, bus.o_PREFIX_PEND);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_double_prefix();
    drive(1'b1, 1'b1, 8'h48, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h48, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE, bus.o_FETCH_CNT}
        !== {1'b1, 8'h48, 3'd1, 2'd2}) begin
      errors++;
      $display("FAIL dbl_pfx got vld=%b op=%h pg=%0d cnt=%0d exp 1 48 1 2",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE, bus.o_FETCH_CNT);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_page5();
    drive(1'b1, 1'b1, 8'h74, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE}
        !== {1'b1, 8'hFF, 3'd5}) begin
      errors++;
      $display("FAIL page5 got vld=%b op=%h pg=%0d exp 1 ff 5",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.o_FETCH_RDY !== 1'b0) begin
      errors++; $display("FAIL hold_rdy got %b exp 0", bus.o_FETCH_RDY);
    end
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_FETCH_CNT}
        !== {1'b1, 8'h00, 2'd1}) begin
      errors++;
      $display("FAIL hold_stable got vld=%b op=%h cnt=%0d exp 1 00 1",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_FETCH_CNT);
    end
    drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.o_FETCH_RDY !== 1'b1) begin
      errors++; $display("FAIL pass_rdy got %b exp 1", bus.o_FETCH_RDY);
    end
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_FETCH_CNT}
        !== {1'b1, 8'h11, 2'd1}) begin
      errors++;
      $display("FAIL b2b got vld=%b op=%h cnt=%0d exp 1 11 1",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_FETCH_CNT);
    end
  endtask

  task automatic test_back_to_back_prefix();
    drive(1'b1, 1'b1, 8'h48, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_OPCODE_PAGE}
        !== {1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL b2b_pfx got vld=%b pend=%b pg=%0d exp 0 1 1",
               bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_OPCODE_PAGE);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.o_PREFIX_PEND, bus.o_FETCH_CNT} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL ack_in_pfx got pend=%b cnt=%0d exp 1 1",
               bus.o_PREFIX_PEND, bus.o_FETCH_CNT);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 8'h64, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_FETCH_CNT, bus.o_OPCODE_PAGE}
        !== {1'b0, 1'b0, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL flush got vld=%b pend=%b cnt=%0d pg=%0d exp 0 0 0 0",
               bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_FETCH_CNT,
               bus.o_OPCODE_PAGE);
    end
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE}
        !== {1'b1, 8'h22, 3'd0}) begin
      errors++;
      $display("FAIL post_flush got vld=%b op=%h pg=%0d exp 1 22 0",
               bus.o_OP_VLD, bus.o_OPCODE, bus.o_OPCODE_PAGE);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_ack_idle();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_FETCH_CNT}
        !== {1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL ack_idle2 got vld=%b pend=%b cnt=%0d exp 0 0 0",
               bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_FETCH_CNT);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 8'h60, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_FETCH_CNT, bus.o_OPCODE_PAGE,
         bus.o_OPCODE, bus.o_FETCH_RDY}
        !== {1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL async_rst got vld=%b pend=%b cnt=%0d pg=%0d op=%h rdy=%b",
               bus.o_OP_VLD, bus.o_PREFIX_PEND, bus.o_FETCH_CNT,
               bus.o_OPCODE_PAGE, bus.o_OPCODE, bus.o_FETCH_RDY);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h60, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.o_PREFIX_PEND, bus.o_OP_VLD, bus.o_OPCODE_PAGE}
        !== {1'b1, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL post_rst got pend=%b vld=%b pg=%0d exp 1 0 2",
               bus.o_PREFIX_PEND, bus.o_OP_VLD, bus.o_OPCODE_PAGE);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.i_MCUCLK_PCEN = 1'b0;
    bus.i_FETCH_VLD   = 1'b0;
    bus.i_FETCH_DATA  = 8'h00;
    bus.i_FLUSH       = 1'b0;
    bus.i_DEC_ACK     = 1'b0;
    test_reset();
    test_single();
    test_prefix();
    test_double_prefix();
    test_page5();
    test_hold();
    test_back_to_back_prefix();
    test_flush();
    test_ack_idle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ika87ad_opfetch.md
IKA87AD_OPFETCH -- requirements
Module: ika87ad_opfetch

Interface
REQ-001 The block SHALL have these ports, clock and reset first: i_EMUCLK  input  1  single system clock, all state on rising edge.
REQ-002 i_RESET_n  input  1  reset, asynchronous and active-low.
REQ-003 i_MCUCLK_PCEN  input  1  clock enable; state SHALL change only on edges where it is 1 (reset excepted).
REQ-004 i_FETCH_VLD  input  1  i_FETCH_DATA holds an opcode-fetch byte.
REQ-005 i_FETCH_DATA  input  8  fetched byte.
REQ-006 i_FLUSH  input  1  abort the partial or held instruction (branch, interrupt entry).
REQ-007 i_DEC_ACK  input  1  downstream decoder/sequencer consumes the held instruction.
REQ-008 o_FETCH_RDY  output  1  block accepts a byte this cycle.
REQ-009 o_OPCODE  output  8  final opcode byte for the decoder.
REQ-010 o_OPCODE_PAGE  output  3  opcode page for the decoder, 0..5.
REQ-011 o_OP_VLD  output  1  o_OPCODE/o_OPCODE_PAGE hold a complete instruction.
REQ-012 o_PREFIX_PEND  output  1  prefix captured, second byte outstanding.
REQ-013 o_FETCH_CNT  output  2  bytes consumed for the current instruction (0, 1 or 2).

Function
REQ-014 Prefix map, page-0 position only: 0x48->page 1, 0x60->2, 0x64->3, 0x70->4, 0x74->5; all other first bytes->page 0, complete in one byte.
REQ-015 A second byte SHALL never be treated as a prefix; any value 0x00..0xFF completes the instruction under the captured page.
REQ-016 States: IDLE (await first byte), PREFIX (await second byte), HOLD (instruction valid). Byte accepted = i_MCUCLK_PCEN & i_FETCH_VLD & o_FETCH_RDY.
REQ-017 o_FETCH_RDY SHALL be 1 in IDLE and PREFIX, and in HOLD only when i_DEC_ACK is 1 (pass-through); 0 otherwise.
REQ-018 IDLE + accepted prefix -> PREFIX: page latched, o_PREFIX_PEND=1, o_FETCH_CNT=1, o_OP_VLD=0.
REQ-019 IDLE + accepted non-prefix -> HOLD: o_OPCODE=byte, o_OPCODE_PAGE=0, o_FETCH_CNT=1, o_OP_VLD=1.
REQ-020 PREFIX + accepted byte -> HOLD: o_OPCODE=byte, page retained, o_FETCH_CNT=2, o_PREFIX_PEND=0, o_OP_VLD=1.
REQ-021 Latency: o_OP_VLD SHALL rise on the enabled edge that accepts the final byte (registered, visible next cycle).
REQ-022 HOLD + enabled i_DEC_ACK without accepted byte -> IDLE; o_OP_VLD=0, o_FETCH_CNT=0; o_OPCODE/o_OPCODE_PAGE keep last values.
REQ-023 HOLD + enabled i_DEC_ACK + accepted byte: consume and process the new byte as in IDLE in the same edge (no bubble).
REQ-024 i_DEC_ACK while o_OP_VLD=0 SHALL be ignored.
REQ-025 HOLD without i_DEC_ACK: outputs stable, fetch bytes not accepted, PCEN-low cycles change nothing.
REQ-026 Enabled i_FLUSH SHALL win over all other inputs: -> IDLE, o_OP_VLD=0, o_PREFIX_PEND=0, o_FETCH_CNT=0, page=0; the byte presented that cycle is discarded.
REQ-027 o_OPCODE_PAGE SHALL never exceed 5.

Reset
REQ-028 While i_RESET_n=0, asynchronously: state IDLE, o_OPCODE=0x00, o_OPCODE_PAGE=0, o_OP_VLD=0, o_PREFIX_PEND=0, o_FETCH_CNT=0; o_FETCH_RDY=1.
REQ-029 Reset asserted mid-instruction (PREFIX or HOLD) SHALL discard it; first byte after release is a page-0 position byte.

Verification
REQ-030 Fetch 0x54 -> next cycle o_OP_VLD=1, o_OPCODE=0x54, page 0, o_FETCH_CNT=1.
REQ-031 Fetch 0x70, 0x6A (PCEN low one cycle between) -> after 0x70 o_PREFIX_PEND=1, o_FETCH_CNT=1; after 0x6A o_OPCODE=0x6A, page 4, o_FETCH_CNT=2.
REQ-032 Fetch 0x48, 0x48 -> instruction page 1, opcode 0x48, not a second prefix.
REQ-033 Hold 0x00, no ack, offer 0x11 -> o_FETCH_RDY=0, outputs unchanged; then ack with 0x11 presented -> next cycle o_OPCODE=0x11, o_OP_VLD=1 continuously.
REQ-034 Fetch 0x64 then i_FLUSH with 0x22 presented -> IDLE, o_OP_VLD=0, o_PREFIX_PEND=0; next fetch 0x22 -> page 0.
REQ-035 Assert i_RESET_n=0 asynchronously in PREFIX -> all outputs at reset values before next clock edge.
